// File: rtl/lp805x_xram_arb_pkg.sv
// rtl/lp805x_xram_arb_pkg.sv - shared state encoding and defaults for the XRAM arbiter
`ifndef LP805X_XRAM_ARB_TIMEOUT
`define LP805X_XRAM_ARB_TIMEOUT 255
`endif

package lp805x_xram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } arb_state_t;

  localparam int ARB_TIMEOUT_DEFAULT = `LP805X_XRAM_ARB_TIMEOUT;
  localparam int WDT_W               = 8;

  // Owner states are encoded one-hot so the grant vector is the state itself.
  function automatic logic [1:0] state_to_gnt(input arb_state_t s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/lp805x_bus_wdt.sv
// rtl/lp805x_bus_wdt.sv - bus watchdog counting unacknowledged strobe cycles
module lp805x_bus_wdt
  import lp805x_xram_arb_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  input  logic i_stb,
  input  logic i_ack,
  output logic o_expire
);

  localparam logic [WDT_W-1:0] LP_LIMIT = WDT_W'(TIMEOUT);

  logic [WDT_W-1:0] r_cnt;
  logic             w_pending;

  assign w_pending = i_active & i_stb & ~i_ack;
  // An ack in the limit cycle masks expiry because it also clears w_pending.
  assign o_expire  = w_pending & (r_cnt == LP_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!w_pending) begin
      r_cnt <= '0;
    end else if (r_cnt != LP_LIMIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lp805x_xram_arb.sv
// rtl/lp805x_xram_arb.sv - two-master round-robin XRAM bus arbiter with watchdog
module lp805x_xram_arb
  import lp805x_xram_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [DATA_W-1:0] s_dat_o,
  input  logic [DATA_W-1:0] s_dat_i,
  input  logic              s_ack_i,
  output logic [1:0]        gnt_o
);

  arb_state_t r_state;
  logic       r_last_gnt;
  logic [1:0] r_blk;
  logic       w_own0;
  logic       w_own1;
  logic       w_req0;
  logic       w_req1;
  logic       w_expire;

  assign w_own0 = (r_state == ST_OWN0);
  assign w_own1 = (r_state == ST_OWN1);
  // A master terminated by the watchdog must drop cyc once before it may compete again.
  assign w_req0 = m0_cyc_i & ~r_blk[0];
  assign w_req1 = m1_cyc_i & ~r_blk[1];

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= 1'b1;
      r_blk      <= 2'b00;
    end else begin
      if (!m0_cyc_i) r_blk[0] <= 1'b0;
      if (!m1_cyc_i) r_blk[1] <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req0 && (!w_req1 || r_last_gnt)) begin
            r_state <= ST_OWN0;
          end else if (w_req1) begin
            r_state <= ST_OWN1;
          end
        end
        ST_OWN0: begin
          if (!m0_cyc_i) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= 1'b0;
          end else if (w_expire) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= 1'b0;
            r_blk[0]   <= 1'b1;
          end
        end
        ST_OWN1: begin
          if (!m1_cyc_i) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= 1'b1;
          end else if (w_expire) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= 1'b1;
            r_blk[1]   <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_cyc_o  = (w_own0 & m0_cyc_i) | (w_own1 & m1_cyc_i);
  assign s_stb_o  = (w_own0 & m0_stb_i) | (w_own1 & m1_stb_i);
  assign s_we_o   = (w_own0 & m0_we_i)  | (w_own1 & m1_we_i);
  assign s_adr_o  = w_own0 ? m0_adr_i : (w_own1 ? m1_adr_i : '0);
  assign s_dat_o  = w_own0 ? m0_dat_i : (w_own1 ? m1_dat_i : '0);

  assign m0_ack_o = w_own0 & s_ack_i;
  assign m1_ack_o = w_own1 & s_ack_i;
  assign m0_dat_o = w_own0 ? s_dat_i : '0;
  assign m1_dat_o = w_own1 ? s_dat_i : '0;
  assign m0_err_o = w_own0 & w_expire;
  assign m1_err_o = w_own1 & w_expire;

  assign gnt_o    = state_to_gnt(r_state);

  lp805x_bus_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_i),
    .i_active (w_own0 | w_own1),
    .i_stb    (s_stb_o),
    .i_ack    (s_ack_i),
    .o_expire (w_expire)
  );

endmodule

// File: tb/tb_lp805x_xram_arb.sv
// tb/tb_lp805x_xram_arb.sv - self-checking bench for the XRAM arbiter
module tb_lp805x_xram_arb;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc [2];
  logic        stb [2];
  logic        we  [2];
  logic [15:0] adr [2];
  logic [7:0]  wdat[2];
  wire  [7:0]  rdat[2];
  wire         ack [2];
  wire         err [2];
  wire         s_cyc, s_stb, s_we;
  wire  [15:0] s_adr;
  wire  [7:0]  s_dout;
  logic [7:0]  s_din;
  logic        s_ack;
  wire  [1:0]  gnt;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [7:0]  mem [64];
  int          lat;
  int          exp_m;

  lp805x_xram_arb #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(TO)) dut (
    .wb_clk_i (clk),     .wb_rst_i (rst_n),
    .m0_cyc_i (cyc[0]),  .m0_stb_i (stb[0]), .m0_we_i (we[0]),
    .m0_adr_i (adr[0]),  .m0_dat_i (wdat[0]), .m0_dat_o (rdat[0]),
    .m0_ack_o (ack[0]),  .m0_err_o (err[0]),
    .m1_cyc_i (cyc[1]),  .m1_stb_i (stb[1]), .m1_we_i (we[1]),
    .m1_adr_i (adr[1]),  .m1_dat_i (wdat[1]), .m1_dat_o (rdat[1]),
    .m1_ack_o (ack[1]),  .m1_err_o (err[1]),
    .s_cyc_o  (s_cyc),   .s_stb_o  (s_stb),  .s_we_o  (s_we),
    .s_adr_o  (s_adr),   .s_dat_o  (s_dout), .s_dat_i (s_din),
    .s_ack_i  (s_ack),   .gnt_o    (gnt)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [1:0] oh(input int m);
    return (m == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One single-word transfer by master m; the bench plays the slave backed by mem[].
  // Returns in the IDLE cycle after release; lat = cycles from cyc to grant.
  task automatic xfer(input int m, input logic w, input logic [15:0] a, input logic [7:0] d,
                      input int dly, output int lat_o);
    int         o;
    logic [7:0] exp_rd;
    o = 1 - m;
    cyc[m] = 1'b1; stb[m] = 1'b1; we[m] = w; adr[m] = a; wdat[m] = d; s_ack = 1'b0;
    #1;
    lat_o = 0;
    while (gnt !== oh(m) && lat_o < 40) begin
      step();
      lat_o++;
    end
    chk("grant_reached", gnt, oh(m));
    for (int i = 0; i < dly; i++) begin
      chk("wait_s_adr", s_adr, a);
      chk("wait_s_stb", s_stb, 1);
      chk("wait_ack", ack[m], 0);
      chk("wait_other_ack", ack[o], 0);
      step();
    end
    exp_rd = mem[a[5:0]];
    s_din  = w ? 8'($urandom) : exp_rd;
    s_ack  = 1'b1;
    #1;
    chk("s_adr", s_adr, a);
    chk("s_we", s_we, w);
    if (w) chk("s_dat", s_dout, d);
    chk("ack_owner", ack[m], 1);
    chk("ack_other", ack[o], 0);
    chk("err_owner", err[m], 0);
    chk("rdat_other", rdat[o], 0);
    if (!w) chk("rd_data", rdat[m], exp_rd);
    else    mem[a[5:0]] = d;
    step();
    cyc[m] = 1'b0; stb[m] = 1'b0; s_ack = 1'b0;
    #1;
    chk("hold_on_drop", gnt, oh(m));
    chk("s_cyc_drop", s_cyc, 0);
    step();
    chk("release_idle", gnt, 2'b00);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 0; stb[i] = 0; we[i] = 0; adr[i] = '0; wdat[i] = '0;
    end
    s_din = '0; s_ack = 0; rst_n = 0;
    #3;
    chk("rst_gnt", gnt, 0);
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_adr", s_adr, 0);
    chk("rst_ack0", ack[0], 0);
    chk("rst_err1", err[1], 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Contention out of reset: m0 first, m1 two cycles after m0 drops.
    cyc[1] = 1; stb[1] = 1; we[1] = 0; adr[1] = 16'h0003;
    xfer(0, 1'b1, 16'h0004, 8'h3C, 2, lat);
    chk("cont_m0_lat", lat, 1);
    xfer(1, 1'b0, 16'h0003, 8'h00, 1, lat);
    chk("cont_m1_lat", lat, 1);

    // Single master write then readback.
    xfer(0, 1'b1, 16'h0010, 8'hA5, 1, lat);
    chk("single_w_lat", lat, 1);
    xfer(0, 1'b0, 16'h0010, 8'h00, 1, lat);
    chk("single_r_lat", lat, 1);
    chk("single_readback", mem[16], 8'hA5);

    // Round-robin with both masters always requesting; m0 released last.
    exp_m = 1;
    for (int k = 0; k < 8; k++) begin
      cyc[1-exp_m] = 1; stb[1-exp_m] = 1; we[1-exp_m] = 0;
      adr[1-exp_m] = 16'($urandom_range(0, 63));
      xfer(exp_m, 1'($urandom), 16'($urandom_range(0, 63)), 8'($urandom),
           $urandom_range(0, 6), lat);
      chk("rr_lat", lat, 1);
      exp_m = 1 - exp_m;
    end
    cyc[exp_m] = 0; stb[exp_m] = 0;

    // Burst hold by m1 while m0 waits.
    cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 16'h0100; wdat[1] = 8'h77;
    step();
    chk("burst_gnt", gnt, 2'b10);
    cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 16'h0005;
    for (int b = 0; b < 4; b++) begin
      adr[1] = 16'h0100 + 16'(b); stb[1] = 1; s_ack = 1;
      #1;
      chk("burst_adr", s_adr, 16'h0100 + 16'(b));
      chk("burst_ack1", ack[1], 1);
      chk("burst_ack0", ack[0], 0);
      step();
      stb[1] = 0; s_ack = 0;
      #1;
      chk("burst_hold", gnt, 2'b10);
      step();
    end
    cyc[1] = 0;
    #1;
    chk("burst_drop_hold", gnt, 2'b10);
    step();
    chk("burst_idle", gnt, 2'b00);
    xfer(0, 1'b0, 16'h0005, 8'h00, 0, lat);
    chk("burst_m0_lat", lat, 1);

    // Watchdog timeout on m0 with m1 pending.
    cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 16'h0020; wdat[0] = 8'h11; s_ack = 0;
    step();
    chk("to_gnt", gnt, 2'b01);
    cyc[1] = 1; stb[1] = 1; we[1] = 0; adr[1] = 16'h0007;
    #1;
    for (int k = 0; k < TO; k++) begin
      chk("to_early_err", err[0], 0);
      chk("to_s_cyc", s_cyc, 1);
      step();
    end
    chk("to_err", err[0], 1);
    chk("to_err_other", err[1], 0);
    chk("to_err_s_cyc", s_cyc, 1);
    step();
    chk("to_err_pulse", err[0], 0);
    chk("to_s_cyc_low", s_cyc, 0);
    chk("to_s_stb_low", s_stb, 0);
    chk("to_idle", gnt, 2'b00);
    step();
    chk("to_m1_gnt", gnt, 2'b10);
    xfer(1, 1'b0, 16'h0007, 8'h00, 0, lat);
    chk("to_m1_lat", lat, 0);
    step();
    chk("to_blocked", gnt, 2'b00);
    cyc[0] = 0; stb[0] = 0;
    step();
    xfer(0, 1'b1, 16'h0020, 8'h22, 0, lat);
    chk("to_regrant_lat", lat, 1);

    // Ack in the limit cycle wins; counter restarts afterwards.
    cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 16'h0021;
    step();
    chk("ack8_gnt", gnt, 2'b01);
    for (int k = 0; k < TO; k++) begin
      chk("ack8_early_err", err[0], 0);
      step();
    end
    s_ack = 1; s_din = 8'h3C;
    #1;
    chk("ack8_ack", ack[0], 1);
    chk("ack8_no_err", err[0], 0);
    chk("ack8_data", rdat[0], 8'h3C);
    step();
    s_ack = 0;
    #1;
    for (int k = 0; k < TO; k++) begin
      chk("ack8_restart_err", err[0], 0);
      chk("ack8_restart_gnt", gnt, 2'b01);
      step();
    end
    s_ack = 1;
    #1;
    chk("ack8_second_ack", ack[0], 1);
    chk("ack8_second_err", err[0], 0);
    step();
    cyc[0] = 0; stb[0] = 0; s_ack = 0;
    step();
    chk("ack8_idle", gnt, 2'b00);

    // Asynchronous reset mid-access, with m0 owning and m1 pending.
    cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 16'h0033; wdat[0] = 8'hC3;
    step();
    chk("ar_gnt", gnt, 2'b01);
    cyc[1] = 1; stb[1] = 1; s_ack = 1; s_din = 8'h5A;
    #1;
    chk("ar_pre_rdat", rdat[0], 8'h5A);
    chk("ar_pre_sdat", s_dout, 8'hC3);
    #2;
    rst_n = 0;
    #1;
    chk("ar_gnt0", gnt, 0);
    chk("ar_s_cyc", s_cyc, 0);
    chk("ar_s_stb", s_stb, 0);
    chk("ar_s_adr", s_adr, 0);
    chk("ar_s_dat", s_dout, 0);
    chk("ar_ack0", ack[0], 0);
    chk("ar_rdat0", rdat[0], 0);
    chk("ar_err0", err[0], 0);
    step();
    rst_n = 1;
    step();
    chk("ar_first_gnt", gnt, 2'b01);
    cyc[0] = 0; cyc[1] = 0; stb[0] = 0; stb[1] = 0; s_ack = 0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lp805x_xram_arb.md
Name: lp805x_xram_arb

Overview:
- Two-master, one-slave arbiter for the lp805x external data RAM (XRAM) bus.
- Master 0 is the core's MOVX data port; master 1 is a secondary requester (DMA/debug loader).
- Grants ownership round-robin and holds it for the whole bus cycle, including bursts.
- A bus watchdog terminates any transfer the XRAM never acknowledges.

Parameters:
- ADDR_W, 16, XRAM address width.
- DATA_W, 8, data width.
- TIMEOUT, 255, cycles an owner's strobe may stay unacknowledged before error termination (1..255).

Ports:
- wb_clk_i in 1: single clock; everything rises on it.
- wb_rst_i in 1: asynchronous active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i in 1 each: master 0 cycle / strobe / write enable.
- m0_adr_i in ADDR_W: master 0 address.
- m0_dat_i in DATA_W: master 0 write data.
- m0_dat_o out DATA_W: master 0 read data.
- m0_ack_o, m0_err_o out 1 each: master 0 acknowledge / error termination.
- m1_* : identical set for master 1.
- s_cyc_o, s_stb_o, s_we_o out 1 each: slave cycle / strobe / write enable.
- s_adr_o out ADDR_W: slave address.
- s_dat_o out DATA_W: slave write data.
- s_dat_i in DATA_W: slave read data.
- s_ack_i in 1: slave acknowledge.
- gnt_o out 2: one-hot current owner (01 = m0, 10 = m1, 00 = none).

Behaviour:
- FSM states: IDLE, OWN0, OWN1, all registered. Reset enters IDLE with last_gnt=1, so m0 wins the first tie.
- Reset values: gnt_o=00, timeout counter=0, all s_* outputs 0, all m*_ack_o/m*_err_o 0, m*_dat_o 0.
- IDLE:
  - Samples m0_cyc_i, m1_cyc_i.
  - One requester: go to its OWN state next cycle.
  - Both requesting: grant the master that is not last_gnt.
  - Neither requesting: stay in IDLE.
  - Grant latency is 1 cycle from cyc assertion.
- OWNx:
  - Slave outputs are a combinational mux of master x's adr/dat/we/stb; s_cyc_o = mx_cyc_i.
  - mx_ack_o = s_ack_i and mx_dat_o = s_dat_i, both combinational pass-through.
  - The non-owner sees ack=0 and err=0; its dat_o holds 0.
- Release: owner drops cyc → return to IDLE the next cycle and set last_gnt=x.
  - No back-to-back regrant without passing through IDLE: one dead cycle between owners.
  - Bursts (cyc held, stb toggling) keep ownership indefinitely.
- Watchdog:
  - The counter increments each OWNx cycle with stb high and s_ack_i low; it clears on ack, on stb low, or in IDLE.
  - When the counter equals TIMEOUT: assert mx_err_o for exactly 1 cycle, force s_cyc_o/s_stb_o low from the next cycle, set last_gnt=x, and go to IDLE.
  - Stay in IDLE until the owner drops cyc; a cyc held high after an error is not regranted until it has been low for one cycle.
- Simultaneous s_ack_i and timeout in the same cycle: ack wins, no err, counter clears.
- The non-owner may assert cyc at any time. It waits with no effect on the bus; requests are never lost and are serviced in the next IDLE.
- Reset mid-transfer: all outputs drop asynchronously to their reset values; an in-flight slave access is abandoned.
- Width: counter is 8 bits and saturates at TIMEOUT; there is no wrap-around.

Decomposition:
- Shared package / defines include (alongside oc8051_defines.v):
  - FSM state encodings: IDLE=2'b00, OWN0=2'b01, OWN1=2'b10.
  - `LP805X_XRAM_ARB_TIMEOUT default.
- One natural sub-module: lp805x_bus_wdt, the watchdog counter with inputs active/stb/ack and one-cycle output expire.
- Muxing and the FSM stay in the top module.

Test Plan:
- Single master:
  - Stimulus: m0 writes 0xA5 to 0x0010, slave acks 1 cycle after stb; then m0 reads it back.
  - Required: gnt_o=01 one cycle after cyc; s_adr_o=0x0010, s_dat_o=0xA5; readback m0_dat_o=0xA5 on ack; gnt_o=00 the cycle after cyc drops.
- Contention:
  - Stimulus: m0 and m1 assert cyc in the same cycle out of reset.
  - Required: m0 granted first. m1 is granted exactly 2 cycles after m0 drops cyc (1 cycle release to IDLE, 1 cycle grant). m1_ack_o stays 0 throughout m0's tenure.
- Round-robin fairness:
  - Stimulus: both masters hold cyc continuously, 1-word cycles, for 8 transfers.
  - Required: grants alternate m0, m1, m0, …, 4 each.
- Burst hold:
  - Stimulus: m1 holds cyc for a 4-beat burst (addresses 0x0100..0x0103) while m0 requests.
  - Required: no grant change until m1 drops cyc; m0 is then served.
- Timeout:
  - Stimulus: TIMEOUT=8; slave never acks m0.
  - Required: m0_err_o pulses 1 cycle after 8 unacked strobe cycles; s_cyc_o low the next cycle; state IDLE; m1 pending is granted next. Also check ack arriving on cycle 8 produces ack, not err.
- Async reset:
  - Stimulus: drive wb_rst_i low mid-burst, between clock edges.
  - Required: all outputs go to 0 immediately without a clock; the first grant after reset goes to m0.
